// File: rtl/dibu_loader_pkg.sv
// Shared definitions for the dibu program loader: state encoding, default
// frame start marker and the bytes-per-instruction helper.
package dibu_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_CHK   = 3'd4,
      S_RUN   = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   localparam logic [7:0] START_BYTE_DEF = 8'hA5;

   // BYTES_PER_WORD for a given instruction width
   function automatic int bytes_per_word(input int instr_w);
      return instr_w / 8;
   endfunction

endpackage

// File: rtl/dibu_loader_if.sv
// Byte-stream handshake between the I/O byte source (master) and the loader (slave).
interface dibu_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/dibu_loader_word_packer.sv
// Shifts incoming bytes MSB-first into an instruction word and flags the
// byte that completes the word.
module loader_word_packer
   import dibu_loader_pkg::*;
#(
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               shift_en,
   input  logic [7:0]         byte_in,
   output logic [INSTR_W-1:0] word_next,
   output logic               last_byte
);
   localparam int BYTES_PER_WORD = bytes_per_word(INSTR_W);
   localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

   logic [CNT_W-1:0]   cnt;
   logic [INSTR_W-1:0] word;

   // word_next already contains the byte being accepted this cycle
   assign word_next = (word << 8) | INSTR_W'(byte_in);
   assign last_byte = (cnt == CNT_W'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         word <= '0;
      end else if (clr) begin
         cnt  <= '0;
         word <= '0;
      end else if (shift_en) begin
         word <= word_next;
         cnt  <= last_byte ? '0 : cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/dibu_loader.sv
// Program loader / run controller for the dibu datapath.
// Define DIBU_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte per frame.
//
// state | meaning
// IDLE  | discard bytes until the start marker
// LEN   | next byte is the word count N
// DATA  | collecting bytes of one instruction word
// WRITE | one-cycle code memory write strobe
// CHK   | next byte is compared with the XOR of the data bytes
// RUN   | program loaded, datapath running
// ERR   | checksum mismatch, datapath held
module dibu_loader
   import dibu_loader_pkg::*;
#(
   parameter int         INSTR_W    = 16,
   parameter int         ADDR_W     = 8,
   parameter logic [7:0] START_BYTE = START_BYTE_DEF
) (
   input  logic               clk,
   input  logic               rst,
   dibu_loader_if.slave       rx,
   output logic               code_w_en,
   output logic [ADDR_W-1:0]  code_addr,
   output logic [INSTR_W-1:0] code_data,
   output logic               run,
   output logic               dp_hold,
   output logic               busy,
   output logic               err
);
`ifdef DIBU_LOADER_CHECKSUM_EN
   localparam state_t END_STATE = S_CHK;
`else
   localparam state_t END_STATE = S_RUN;
`endif

   state_t             state;
   logic [7:0]         n_words;
   logic [7:0]         wcnt;
   logic               acc;
   logic               is_start;
   logic [INSTR_W-1:0] word_next;
   logic               last_byte;

   assign acc      = rx.rx_valid & rx.rx_ready;
   assign is_start = (rx.rx_data == START_BYTE);

   assign rx.rx_ready = (state != S_WRITE);
   assign busy        = (state == S_LEN) || (state == S_DATA) ||
                        (state == S_WRITE) || (state == S_CHK);
   assign run         = (state == S_RUN);
   assign dp_hold     = (state != S_RUN);

   loader_word_packer #(.INSTR_W(INSTR_W)) u_packer (
      .clk       (clk),
      .rst       (rst),
      .clr       (state == S_LEN && acc),
      .shift_en  (state == S_DATA && acc),
      .byte_in   (rx.rx_data),
      .word_next (word_next),
      .last_byte (last_byte)
   );

`ifdef DIBU_LOADER_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         csum <= '0;
      else if (state == S_LEN && acc)
         csum <= '0;
      else if (state == S_DATA && acc)
         csum <= csum ^ rx.rx_data;
   end

   assign err = (state == S_ERR);
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         code_w_en <= 1'b0;
         code_addr <= '0;
         code_data <= '0;
         n_words   <= '0;
         wcnt      <= '0;
      end else begin
         code_w_en <= 1'b0;
         case (state)
            S_IDLE:
               if (acc && is_start) state <= S_LEN;
            S_LEN:
               if (acc) begin
                  n_words   <= rx.rx_data;
                  wcnt      <= '0;
                  code_addr <= '0;
                  state     <= (rx.rx_data == 8'd0) ? END_STATE : S_DATA;
               end
            S_DATA:
               if (acc && last_byte) begin
                  state     <= S_WRITE;
                  code_w_en <= 1'b1;
                  code_data <= word_next;
               end
            S_WRITE: begin
               code_addr <= code_addr + ADDR_W'(1);
               wcnt      <= wcnt + 8'd1;
               state     <= ((wcnt + 8'd1) == n_words) ? END_STATE : S_DATA;
            end
`ifdef DIBU_LOADER_CHECKSUM_EN
            S_CHK:
               if (acc) state <= (rx.rx_data == csum) ? S_RUN : S_ERR;
            S_RUN, S_ERR:
               if (acc && is_start) state <= S_LEN;
`else
            S_RUN:
               if (acc && is_start) state <= S_LEN;
`endif
            default:
               state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dibu_loader.sv
// Directed bench for dibu_loader: stimulus pushes expected code writes into a
// queue that an independent monitor pops on every code_w_en strobe.
module tb_dibu_loader;
   localparam int INSTR_W = 16;
   localparam int ADDR_W  = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               code_w_en;
   logic [ADDR_W-1:0]  code_addr;
   logic [INSTR_W-1:0] code_data;
   logic               run, dp_hold, busy, err;

   dibu_loader_if bus ();

   dibu_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .START_BYTE(8'hA5)) dut (
      .clk       (clk),
      .rst       (rst_n),
      .rx        (bus.slave),
      .code_w_en (code_w_en),
      .code_addr (code_addr),
      .code_data (code_data),
      .run       (run),
      .dp_hold   (dp_hold),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int ready_low_cnt = 0;
   logic [ADDR_W+INSTR_W-1:0] exp_q[$];
   logic [7:0] frm[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (code_w_en) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %h data %h expected no write", code_addr, code_data);
            end else begin
               check("code_write", 32'({code_addr, code_data}), 32'(exp_q.pop_front()));
            end
         end
         if (!bus.rx_ready) ready_low_cnt++;
      end
   end

   // Called at a negedge; returns at the negedge after the byte is accepted, valid still high.
   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      while (!bus.rx_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
      @(negedge clk);
   endtask

   task automatic send_frm();
      foreach (frm[i]) send_byte(frm[i]);
      bus.rx_valid = 1'b0;
   endtask

   task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic check_run_start();
`ifndef DIBU_LOADER_CHECKSUM_EN
      check("run_low_during_write", 32'(run), 32'd0);
      @(negedge clk);
`endif
      check("run_high", 32'(run), 32'd1);
      check("dp_hold_low", 32'(dp_hold), 32'd0);
      check("busy_low", 32'(busy), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
      check({tag, "_run"}, 32'(run), 32'd0);
      check({tag, "_dp_hold"}, 32'(dp_hold), 32'd1);
      check({tag, "_w_en"}, 32'(code_w_en), 32'd0);
      check({tag, "_addr"}, 32'(code_addr), 32'd0);
      check({tag, "_data"}, 32'(code_data), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      #12;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Garbage byte in IDLE is discarded
      send_byte(8'h00);
      bus.rx_valid = 1'b0;
      check("idle_rx_ready", 32'(bus.rx_ready), 32'd1);
      check("idle_run", 32'(run), 32'd0);
      check("idle_dp_hold", 32'(dp_hold), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);

      // Two-word frame
      expect_wr(8'd0, 16'h1234);
      expect_wr(8'd1, 16'hABCD);
      frm = {8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef DIBU_LOADER_CHECKSUM_EN
      frm.push_back(8'h40);
`endif
      send_frm();
      check_run_start();

      // Reload from RUN: run drops the cycle after A5
      frm = {8'hA5};
      send_frm();
      check("reload_run_low", 32'(run), 32'd0);
      check("reload_dp_hold", 32'(dp_hold), 32'd1);
      check("reload_busy", 32'(busy), 32'd1);
      expect_wr(8'd0, 16'h0007);
      frm = {8'h01, 8'h00, 8'h07};
`ifdef DIBU_LOADER_CHECKSUM_EN
      frm.push_back(8'h07);
`endif
      send_frm();
      check_run_start();

      // Three words with rx_valid held: one ready bubble per word
      @(negedge clk);
      base = ready_low_cnt;
      expect_wr(8'd0, 16'h0102);
      expect_wr(8'd1, 16'h0304);
      expect_wr(8'd2, 16'h0506);
      frm = {8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
`ifdef DIBU_LOADER_CHECKSUM_EN
      frm.push_back(8'h07);
`endif
      send_frm();
      check_run_start();
      @(negedge clk);
      check("ready_bubbles", 32'(ready_low_cnt - base), 32'd3);

`ifdef DIBU_LOADER_CHECKSUM_EN
      expect_wr(8'd0, 16'h1234);
      frm = {8'hA5, 8'h01, 8'h12, 8'h34, 8'h26};
      send_frm();
      check("csum_ok_run", 32'(run), 32'd1);
      check("csum_ok_err", 32'(err), 32'd0);
      expect_wr(8'd0, 16'h1234);
      frm = {8'hA5, 8'h01, 8'h12, 8'h34, 8'h27};
      send_frm();
      check("csum_bad_err", 32'(err), 32'd1);
      check("csum_bad_run", 32'(run), 32'd0);
      check("csum_bad_dp_hold", 32'(dp_hold), 32'd1);
      frm = {8'hA5};
      send_frm();
      check("err_cleared_by_start", 32'(err), 32'd0);
      frm = {8'h00, 8'h00};
      send_frm();
      check("empty_frame_run", 32'(run), 32'd1);
`endif

      // Reset in the middle of a word
      frm = {8'hA5, 8'h01, 8'h12};
      send_frm();
      check("mid_frame_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      expect_wr(8'd0, 16'h5678);
      frm = {8'hA5, 8'h01, 8'h56, 8'h78};
`ifdef DIBU_LOADER_CHECKSUM_EN
      frm.push_back(8'h2E);
`endif
      send_frm();
      check_run_start();

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
